// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module      : mem_stage_lsu
// Description : MEM-stage load/store unit. Drives a req/ack data bus with
//               byte enables, stalls the pipeline until the access completes
//               and returns sign/zero-extended load data.
//               Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [2:0]        mask_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       write_data_in,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              bus_fault,
    output logic              misalign_fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [31:0]       bus_rdata
);

    localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] c_SZ_B = 2'b00;
    localparam logic [1:0] c_SZ_H = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_timer;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic        r_is_load;

    logic        w_access;
    logic        w_issue;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_ext;

    assign w_access = mem_read_in | mem_write_in;

    // Size comes from funct3[1:0] only; 10 and 11 both behave as a word.
    always_comb begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = write_data_in;
        case (mask_in[1:0])
            c_SZ_B: begin
                w_off   = addr_in[1:0];
                w_be    = 4'b0001 << addr_in[1:0];
                w_wdata = {4{write_data_in[7:0]}};
            end
            c_SZ_H: begin
                w_off   = {addr_in[1], 1'b0};
                w_be    = 4'b0011 << {addr_in[1], 1'b0};
                w_wdata = {2{write_data_in[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((mask_in[1:0] == c_SZ_H) && addr_in[0]) ||
                        (mask_in[1] && (addr_in[1:0] != 2'b00));
    assign w_issue    = w_access & ~w_misalign;
`else
    assign w_issue    = w_access;
    assign misalign_fault = 1'b0;
`endif

    assign w_shifted = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_ext = w_shifted;
        case (r_size)
            c_SZ_B:  w_load_ext = {{24{w_shifted[7] & ~r_unsigned}}, w_shifted[7:0]};
            c_SZ_H:  w_load_ext = {{16{w_shifted[15] & ~r_unsigned}}, w_shifted[15:0]};
            default: ;
        endcase
    end

    // Stall is forced low while reset is held so a held-in-reset pipeline is not frozen.
    always_comb begin
        stall = 1'b0;
        case (r_state)
            S_IDLE:  stall = w_issue;
            S_WAIT:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
        stall = stall & reset;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_next = S_WAIT;
            S_WAIT:  if (bus_ack || (r_timer == c_TIMER_LAST)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer    <= 8'd0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_is_load  <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= 4'b0000;
            bus_wdata  <= 32'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            bus_fault  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
        end else begin
            load_valid <= 1'b0;
            bus_fault  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_fault <= (r_state == S_IDLE) && w_access && w_misalign;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        bus_req    <= 1'b1;
                        bus_we     <= mem_write_in;
                        bus_addr   <= {addr_in[ADDR_W-1:2], 2'b00};
                        bus_be     <= w_be;
                        bus_wdata  <= w_wdata;
                        r_size     <= mask_in[1:0];
                        r_unsigned <= mask_in[2];
                        r_off      <= w_off;
                        r_is_load  <= ~mem_write_in;
                        r_timer    <= 8'd0;
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + 8'd1;
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (r_is_load) begin
                            load_data  <= w_load_ext;
                            load_valid <= 1'b1;
                        end
                        if (bus_err) begin
                            bus_fault <= 1'b1;
                            load_data <= 32'd0;
                        end
                    end else if (r_timer == c_TIMER_LAST) begin
                        bus_req   <= 1'b0;
                        bus_fault <= 1'b1;
                        load_data <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu (vector table plus
//               hand-written reset / misalignment sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

    localparam int TIMEOUT = 16;
    localparam int NO_ACK  = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [2:0]  mask_in = 3'b000;
    logic [31:0] addr_in = 32'd0;
    logic [31:0] write_data_in = 32'd0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_fault;
    logic        misalign_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TIMEOUT), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mask_in(mask_in), .addr_in(addr_in), .write_data_in(write_data_in),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .bus_fault(bus_fault), .misalign_fault(misalign_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          delay;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_lv;
        logic [31:0] e_ld;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] mask,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err, input int delay,
                                input logic e_we, input logic [31:0] e_addr,
                                input logic [3:0] e_be, input logic [31:0] e_wdata,
                                input logic e_lv, input logic [31:0] e_ld,
                                input logic e_fault);
        vec_t v;
        v.rd = rd; v.wr = wr; v.mask = mask; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.delay = delay; v.e_we = e_we;
        v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_lv = e_lv;
        v.e_ld = e_ld; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_access(input vec_t v);
        vec_t e;
        int   n;
        int   st;
        int   exp_n;
        mem_read_in   = v.rd;
        mem_write_in  = v.wr;
        mask_in       = v.mask;
        addr_in       = v.addr;
        write_data_in = v.wdata;
        exp_q.push_back(v);
        #1;
        chk("stall_idle", stall, 1);
        @(posedge clk); #1;
        e = exp_q[0];
        chk("bus_req", bus_req, 1);
        chk("bus_we", bus_we, e.e_we);
        chk("bus_addr", bus_addr, e.e_addr);
        chk("bus_be", bus_be, e.e_be);
        if (e.e_we) chk("bus_wdata", bus_wdata, e.e_wdata);
        chk("misalign_quiet", misalign_fault, 0);
        n  = 0;
        st = 1;
        while (bus_req === 1'b1 && n < 40) begin
            st += int'(stall);
            if (n == v.delay) begin
                bus_ack   = 1'b1;
                bus_err   = v.err;
                bus_rdata = v.rdata;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            bus_err = 1'b0;
            n++;
        end
        e = exp_q.pop_front();
        exp_n = (e.delay == NO_ACK) ? TIMEOUT : e.delay + 1;
        chk("wait_cycles", n, exp_n);
        chk("stall_cycles", st, exp_n + 1);
        chk("stall_done", stall, 0);
        chk("load_valid", load_valid, e.e_lv);
        chk("bus_fault", bus_fault, e.e_fault);
        if (e.e_lv || e.e_fault) chk("load_data", load_data, e.e_ld);
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        @(posedge clk); #1;
        chk("lv_clear", load_valid, 0);
        chk("fault_clear", bus_fault, 0);
        chk("req_idle", bus_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        mem_read_in = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_load_valid", load_valid, 0);
        chk("rst_bus_fault", bus_fault, 0);
        chk("rst_misalign", misalign_fault, 0);
        mem_read_in = 1'b0;
        reset = 1'b1;

        // No access: zero stall, and a stray ack in IDLE is ignored.
        for (int i = 0; i < 3; i++) begin
            bus_ack   = (i == 1);
            bus_rdata = 32'h12345678;
            @(posedge clk); #1;
            chk("noacc_stall", stall, 0);
            chk("noacc_req", bus_req, 0);
            chk("noacc_lv", load_valid, 0);
        end
        bus_ack = 1'b0;

        vecs.push_back(mk(1,0,3'b010,32'h100,0,32'hDEADBEEF,0,0,     0,32'h100,4'hF,0,1,32'hDEADBEEF,0));
        vecs.push_back(mk(1,0,3'b000,32'h203,0,32'h80112233,0,2,     0,32'h200,4'h8,0,1,32'hFFFFFF80,0));
        vecs.push_back(mk(1,0,3'b100,32'h203,0,32'h80112233,0,0,     0,32'h200,4'h8,0,1,32'h00000080,0));
        vecs.push_back(mk(0,1,3'b001,32'h42,32'h0000ABCD,0,0,1,      1,32'h40,4'hC,32'hABCDABCD,0,0,0));
        vecs.push_back(mk(1,0,3'b001,32'h102,0,32'h80011234,0,0,     0,32'h100,4'hC,0,1,32'hFFFF8001,0));
        vecs.push_back(mk(1,0,3'b101,32'h100,0,32'h0000F00F,0,1,     0,32'h100,4'h3,0,1,32'h0000F00F,0));
        vecs.push_back(mk(0,1,3'b000,32'h01,32'h123456A5,0,0,0,      1,32'h0,4'h2,32'hA5A5A5A5,0,0,0));
        vecs.push_back(mk(0,1,3'b010,32'h10,32'h12345678,0,0,3,      1,32'h10,4'hF,32'h12345678,0,0,0));
        vecs.push_back(mk(1,0,3'b000,32'h200,0,32'h0000007F,0,0,     0,32'h200,4'h1,0,1,32'h0000007F,0));
        vecs.push_back(mk(1,0,3'b010,32'h300,0,0,0,NO_ACK,           0,32'h300,4'hF,0,0,32'h0,1));
        vecs.push_back(mk(1,0,3'b101,32'h106,0,32'hABCD0000,0,0,     0,32'h104,4'hC,0,1,32'h0000ABCD,0));
        vecs.push_back(mk(1,0,3'b010,32'h304,0,32'h55555555,1,1,     0,32'h304,4'hF,0,1,32'h0,1));
        vecs.push_back(mk(1,1,3'b010,32'h8,32'hCAFEF00D,0,0,0,       1,32'h8,4'hF,32'hCAFEF00D,0,0,0));
`ifndef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(1,0,3'b001,32'h101,0,32'h00007FFF,0,0,     0,32'h100,4'h3,0,1,32'h00007FFF,0));
        vecs.push_back(mk(1,0,3'b011,32'h203,0,32'h11223344,0,1,     0,32'h200,4'hF,0,1,32'h11223344,0));
`endif
        foreach (vecs[i]) run_access(vecs[i]);

`ifdef LSU_MISALIGN_TRAP_EN
        mem_read_in = 1'b1;
        mask_in     = 3'b001;
        addr_in     = 32'h101;
        #1;
        chk("trap_stall", stall, 0);
        @(posedge clk); #1;
        chk("trap_fault", misalign_fault, 1);
        chk("trap_no_req", bus_req, 0);
        chk("trap_no_lv", load_valid, 0);
        mem_read_in = 1'b0;
        @(posedge clk); #1;
        chk("trap_clear", misalign_fault, 0);
        chk("trap_req_idle", bus_req, 0);
`endif

        // Reset in the middle of an access, then a late ack.
        mem_read_in = 1'b1;
        mask_in     = 3'b010;
        addr_in     = 32'h400;
        @(posedge clk); #1;
        chk("mid_req_up", bus_req, 1);
        reset = 1'b0;
        #1;
        chk("mid_req_drop", bus_req, 0);
        chk("mid_stall", stall, 0);
        chk("mid_lv", load_valid, 0);
        mem_read_in = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("late_ack_lv", load_valid, 0);
        chk("late_ack_req", bus_req, 0);
        chk("late_ack_stall", stall, 0);
        chk("late_ack_data", load_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
